// File: rtl/heap_medium_pkg.sv
// Shared state encoding and width helpers for the multi-channel heap medium.
package heap_medium_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    function automatic int addr_size(input int addrs);
        return (addrs > 1) ? $clog2(addrs) : 1;
    endfunction

    function automatic int bram_addr_size(input int addrs, input int pieces);
        return (addrs * pieces > 1) ? $clog2(addrs * pieces) : 1;
    endfunction

    function automatic int word_width(input int pieces, input int bram_width);
        return pieces * bram_width;
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/heap_medium_mc_rr_arbiter.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves to the slot after the winner whenever the grant is taken.
module rr_arbiter
    import heap_medium_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = index_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back toward the pointer so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (req[cand]) begin
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/heap_medium_mc.sv
// Multi-channel heap medium: round-robin client arbitration, wide words serialised over one BRAM port.
// Optional HEAP_MEDIUM_MC_PIECE_MASK_EN adds a per-piece write mask latched at grant.
module heap_medium_mc
    import heap_medium_pkg::*;
#(
    parameter int ADDRS        = 256,
    parameter int BRAM_WIDTH   = 64,
    parameter int PIECES       = 16,
    parameter int CHANNELS     = 4,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_SIZE      = addr_size(ADDRS),
    localparam int BRAM_ADDR_SIZE = bram_addr_size(ADDRS, PIECES),
    localparam int WIDTH          = word_width(PIECES, BRAM_WIDTH)
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [CHANNELS-1:0][ADDR_SIZE-1:0] addr_in,
    input  logic [CHANNELS-1:0][WIDTH-1:0]     data_in,
    input  logic [CHANNELS-1:0]                read_enable,
    input  logic [CHANNELS-1:0]                write_enable,
`ifdef HEAP_MEDIUM_MC_PIECE_MASK_EN
    input  logic [CHANNELS-1:0][PIECES-1:0]    piece_mask_in,
`endif
    output logic [CHANNELS-1:0][WIDTH-1:0]     data_out,
    output logic [CHANNELS-1:0]                finished_out,
    input  logic [BRAM_WIDTH-1:0]              bram_dout,
    output logic [BRAM_ADDR_SIZE-1:0]          bram_addr,
    output logic                               bram_we,
    output logic                               bram_regce,
    output logic [BRAM_WIDTH-1:0]              bram_din
);

    localparam int PIECE_W = index_width(PIECES);
    localparam int CH_W    = index_width(CHANNELS);

    state_t state;
    state_t state_nxt;

    logic [CH_W-1:0]           grant_idx;
    logic                      grant_valid;
    logic                      advance;
    logic [CH_W-1:0]           grant_q;
    logic [ADDR_SIZE-1:0]      addr_q;
    logic [WIDTH-1:0]          data_q;
`ifdef HEAP_MEDIUM_MC_PIECE_MASK_EN
    logic [PIECES-1:0]         mask_q;
`endif
    logic [PIECE_W-1:0]        piece;
    logic                      last_piece;
    logic [BRAM_ADDR_SIZE-1:0] piece_addr;

    logic [READ_LATENCY-1:0]   vld_p;
    logic [PIECE_W-1:0]        idx_p [READ_LATENCY];
    logic                      cap_vld;
    logic [PIECE_W-1:0]        cap_idx;
    logic                      last_cap;
    logic [WIDTH-1:0]          rd_buf;
    logic [WIDTH-1:0]          rd_word;

    rr_arbiter #(
        .N(CHANNELS)
    ) u_arb (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .req        (read_enable | write_enable),
        .advance    (advance),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign advance    = (state == IDLE) && grant_valid;
    assign last_piece = (piece == PIECE_W'(PIECES - 1));
    // Wide address scaled to BRAM words; the cast wraps out-of-range addresses silently.
    assign piece_addr = BRAM_ADDR_SIZE'(int'(addr_q) * PIECES + int'(piece));

    assign cap_vld    = vld_p[READ_LATENCY-1];
    assign cap_idx    = idx_p[READ_LATENCY-1];
    assign last_cap   = cap_vld && (cap_idx == PIECE_W'(PIECES - 1));
    assign bram_regce = (state == READ) || (|vld_p);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            piece   <= '0;
            grant_q <= '0;
            vld_p   <= '0;
        end else begin
            state    <= state_nxt;
            vld_p[0] <= (state == READ);
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            if (state == WRITE || state == READ) begin
                piece <= last_piece ? '0 : piece + 1'b1;
            end else begin
                piece <= '0;
            end
            if (advance) begin
                grant_q <= grant_idx;
            end
        end
    end

    // Transaction payload and capture indices carry no reset; validity lives in the control above.
    always_ff @(posedge clk_in) begin
        if (advance) begin
            addr_q <= addr_in[grant_idx];
            data_q <= data_in[grant_idx];
`ifdef HEAP_MEDIUM_MC_PIECE_MASK_EN
            mask_q <= piece_mask_in[grant_idx];
`endif
        end
        idx_p[0] <= piece;
        for (int i = 1; i < READ_LATENCY; i++) begin
            idx_p[i] <= idx_p[i-1];
        end
        if (cap_vld) begin
            rd_buf <= rd_word;
        end
    end

    always_comb begin
        rd_word = rd_buf;
        rd_word[int'(cap_idx) * BRAM_WIDTH +: BRAM_WIDTH] = bram_dout;
    end

    // Reads assemble in rd_buf and commit whole, so data_out never shows a half-read word.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            data_out <= '0;
        end else if (last_cap) begin
            data_out[grant_q] <= rd_word;
        end
    end

    always_comb begin
        state_nxt    = state;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_din     = '0;
        finished_out = '0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = write_enable[grant_idx] ? WRITE : READ;
                end
            end
            WRITE: begin
                bram_addr = piece_addr;
`ifdef HEAP_MEDIUM_MC_PIECE_MASK_EN
                bram_we   = mask_q[piece];
`else
                bram_we   = 1'b1;
`endif
                bram_din  = data_q[int'(piece) * BRAM_WIDTH +: BRAM_WIDTH];
                if (last_piece) begin
                    state_nxt = DONE;
                end
            end
            READ: begin
                bram_addr = piece_addr;
                if (last_piece) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_cap) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                finished_out[grant_q] = 1'b1;
                state_nxt             = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/heap_medium_mc.md
# heap_medium_mc

Multi-channel successor to the single-client heap medium. Arbitrates round-robin among `CHANNELS` independent clients, such as the CPU, a DMA and a weight loader. Each granted wide-word access is serialised into `PIECES` narrow accesses on one shared BRAM port. Sits between the client-facing memory interfaces and a single-port BRAM with a configurable, registered read latency.

## Interface
Parameters:
- `ADDRS`, 256, wide words stored.
- `BRAM_WIDTH`, 64, BRAM data width.
- `PIECES`, 16, BRAM words per wide word; `WIDTH = PIECES*BRAM_WIDTH`.
- `CHANNELS`, 4, client count, ≥1.
- `READ_LATENCY`, 2, cycles from `bram_addr` to valid `bram_dout` (regce stage included), ≥1.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: synchronous, active-low reset.
- `addr_in` in `[CHANNELS][ADDR_SIZE]`: per-channel wide-word address, `ADDR_SIZE = $clog2(ADDRS)`.
- `data_in` in `[CHANNELS][WIDTH]`: per-channel write data.
- `read_enable` in `[CHANNELS]`: per-channel read request.
- `write_enable` in `[CHANNELS]`: per-channel write request.
- `data_out` out `[CHANNELS][WIDTH]`: per-channel last read result.
- `finished_out` out `[CHANNELS]`: one-cycle completion pulse.
- `bram_dout` in `BRAM_WIDTH`: BRAM read data.
- `bram_addr` out `$clog2(ADDRS*PIECES)`: BRAM address.
- `bram_we` out 1: BRAM write enable.
- `bram_regce` out 1: BRAM output-register enable.
- `bram_din` out `BRAM_WIDTH`: BRAM write data.

## Operation
- Request handshake:
  - A channel requests by holding `read_enable` or `write_enable` high until its `finished_out` pulses.
  - If both are high, the request is a write.
- Arbitration:
  - Happens only in `IDLE`.
  - Round-robin with the pointer starting at the channel after the last granted one; after reset, channel 0 has priority.
- Latching: on grant, the channel's address, data and op are latched. Later changes to that channel's inputs are ignored until `finished_out`.
- BRAM addressing: `addr*PIECES + piece`. Piece `k` is `data[k*BRAM_WIDTH +: BRAM_WIDTH]`.
- States:
  - `IDLE`: no BRAM activity. Any request → `WRITE` or `READ`; otherwise stay.
  - `WRITE`: `PIECES` cycles, piece counter 0..PIECES-1, `bram_we`=1, `bram_din`=piece k. Counter at PIECES-1 → `DONE`.
  - `READ`: `PIECES` cycles issuing addresses, `bram_we`=0. Counter at PIECES-1 → `DRAIN`.
  - `DRAIN`: `READ_LATENCY` cycles. Captures of `bram_dout` into piece k of the granted channel's `data_out` continue in a delayed-index pipeline started in `READ`. The last capture → `DONE`.
  - `DONE`: one cycle with `finished_out[grant]`=1, then → `IDLE`.
- `bram_regce` is 1 whenever a read capture is pending, 0 otherwise.
- `data_out[c]` changes only when a read on channel c completes; it is held otherwise, including across other channels' traffic.
- The client must deassert its enable in the cycle after `finished_out`; otherwise `IDLE` regrants it, subject to round-robin order.
- An out-of-range address (`addr ≥ ADDRS`) wraps modulo the BRAM address width; no error is reported.

## Timing
- Reset (`rst_in`=0 at edge):
  - Next state is `IDLE`; RR pointer selects channel 0.
  - `finished_out`=0, `bram_we`=0, `bram_regce`=0, `bram_addr`=0, `bram_din`=0, `data_out`=0.
- Reset mid-operation aborts the transaction with no `finished_out`. The BRAM may hold a partially written word.
- Write: request seen in `IDLE` at cycle T; pieces written T+1..T+PIECES; `finished_out` at T+PIECES+1.
- Read: addresses issued T+1..T+PIECES; last capture at T+PIECES+READ_LATENCY; `data_out` valid and `finished_out` at T+PIECES+READ_LATENCY+1.
- Back-to-back: the next grant is evaluated in the cycle after `DONE`, giving a one-cycle `IDLE` gap.

## Configuration
- `HEAP_MEDIUM_MC_PIECE_MASK_EN` defined:
  - Adds input `piece_mask_in [CHANNELS][PIECES]`, latched at grant.
  - During `WRITE`, `bram_we` equals the mask bit for piece k. Masked pieces still occupy a cycle, so latency is unchanged.
  - Reads ignore the mask.
- Undefined: the port is absent and every piece is written.

## Structure
- `heap_medium_pkg`:
  - State enum `IDLE/WRITE/READ/DRAIN/DONE`.
  - Width helper functions for `ADDR_SIZE`, `BRAM_ADDR_SIZE` and `WIDTH`.
- Sub-module `rr_arbiter`:
  - Parameter `N`; inputs `req[N]` and `advance`; outputs `grant_idx` and `grant_valid`.
  - Pointer updates only on `advance`; pointer resets to 0.

## Test plan
- Single-channel write then read: ch0 writes `0xA5..` pattern to addr 3 with PIECES=4, READ_LATENCY=2. Write `finished_out[0]` arrives 5 cycles after the request is sampled; read `finished_out[0]` arrives 7 cycles after; `data_out[0]` matches the pattern; `bram_addr` runs 12..15.
- Round-robin: all four channels request reads simultaneously. Grants are issued in order 0,1,2,3; a re-request from ch0 is served after ch3, not before.
- Isolation: ch1 reads addr 5, then ch2 writes addr 5 with new data. `data_out[1]` holds its old value until ch1 reads again.
- Reset mid-write: assert reset during piece 2 of 4. No `finished_out`, all outputs return to 0 next cycle, and ch0 is granted first afterwards.
- Read+write both high on ch2: performed as a write; `bram_we`=1 for PIECES cycles.
- `HEAP_MEDIUM_MC_PIECE_MASK_EN`: mask `4'b0101` on an overwrite of a known word. Only pieces 0 and 2 change on readback, and latency is unchanged.
